sd_image_server: RTL and testbench

- Responder end of the sector handshake (sd_lba / sd_rd / sd_wr / sd_ack / sd_buff_*) that the ZPU disk bridge drives as initiator.
- Serves 512-byte sectors from a disk image held in a byte-wide backing memory (SDRAM/DDR image cache port), in place of the HPS.
- Read: streams the sector into the requester's sector buffer. Write: drains the buffer back into the image.
- Sits beside hps_io in the emu top; the top muxes which responder drives the buffer port.

---
 rtl/sd_image_server.sv | 219 +++++++++++++++++++++
 tb/tb_sd_image_server.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_image_server.sv
`default_nettype none
// sd_image_server: responder for the sd_lba/sd_rd/sd_wr/sd_ack sector handshake, serving 512-byte
// sectors from a byte-wide image memory. Define SD_IMAGE_WRITE_EN to allow writes back to the image.
module sd_image_server #(
  parameter int unsigned ADDR_W   = 24,
  parameter int unsigned IMG_BASE = 0
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic [31:0]       sd_lba,
  input  logic              sd_rd,
  input  logic              sd_wr,
  output logic              sd_ack,
  output logic [8:0]        sd_buff_addr,
  output logic [7:0]        sd_buff_dout,
  input  logic [7:0]        sd_buff_din,
  output logic              sd_buff_wr,
  input  logic [31:0]       img_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [7:0]        mem_din,
  input  logic [7:0]        mem_dout,
  input  logic              mem_ready,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RD_REQ   = 3'd1,
    S_RD_STORE = 3'd2,
    S_WR_ADDR  = 3'd3,
    S_WR_LATCH = 3'd4,
    S_WR_REQ   = 3'd5,
    S_DONE     = 3'd6
  } state_t;

  state_t              state_q;
  logic                rd_prev_q;
  logic                wr_prev_q;
  logic [8:0]          idx_q;
  logic [ADDR_W-10:0]  blk_q;
  logic                zfill_q;
  logic                hold_q;
  logic                ack_q;
  logic                bwr_q;
  logic                mrd_q;
  logic                mwr_q;
  logic                err_q;
  logic [8:0]          baddr_q;
  logic [7:0]          bdout_q;
  logic [ADDR_W-1:0]   maddr_q;

  logic                rd_edge_d;
  logic                wr_edge_d;
  logic                in_range_d;
  logic [41:0]         end_byte_d;
  logic [8:0]          idx_inc_d;

  assign rd_edge_d  = sd_rd & ~rd_prev_q;
  assign wr_edge_d  = sd_wr & ~wr_prev_q;
  assign idx_inc_d  = idx_q + 9'd1;
  // Widened so (lba+1)*512 can never wrap back into range.
  assign end_byte_d = ({10'd0, sd_lba} + 42'd1) << 9;
  assign in_range_d = (img_size != 32'd0) &&
                      ((sd_lba >> (ADDR_W - 9)) == 32'd0) &&
                      (end_byte_d <= {10'd0, img_size});

  function automatic logic [ADDR_W-1:0] byte_addr(input logic [ADDR_W-10:0] blk,
                                                  input logic [8:0] i);
    return ADDR_W'(IMG_BASE) + {blk, i};
  endfunction

`ifdef SD_IMAGE_WRITE_EN
  logic [7:0] mdin_q;
  assign mem_din = mdin_q;
`else
  logic unused_buff_din;
  assign unused_buff_din = ^sd_buff_din;
  assign mem_din         = 8'd0;
`endif

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= S_IDLE;
      rd_prev_q <= 1'b0;
      wr_prev_q <= 1'b0;
      idx_q     <= '0;
      blk_q     <= '0;
      zfill_q   <= 1'b0;
      hold_q    <= 1'b0;
      ack_q     <= 1'b0;
      bwr_q     <= 1'b0;
      mrd_q     <= 1'b0;
      mwr_q     <= 1'b0;
      err_q     <= 1'b0;
      baddr_q   <= '0;
      bdout_q   <= '0;
      maddr_q   <= '0;
`ifdef SD_IMAGE_WRITE_EN
      mdin_q    <= '0;
`endif
    end else begin
      rd_prev_q <= sd_rd;
      wr_prev_q <= sd_wr;
      err_q     <= 1'b0;
      case (state_q)
        S_IDLE: begin
          idx_q <= '0;
          if (rd_edge_d) begin
            blk_q   <= sd_lba[ADDR_W-10:0];
            ack_q   <= 1'b1;
            baddr_q <= '0;
            if (in_range_d) begin
              maddr_q <= byte_addr(sd_lba[ADDR_W-10:0], 9'd0);
              mrd_q   <= 1'b1;
              err_q   <= wr_edge_d;
              state_q <= S_RD_REQ;
            end else begin
              // Out of range: fill the buffer with zeros, one byte per cycle.
              zfill_q <= 1'b1;
              bdout_q <= 8'd0;
              bwr_q   <= 1'b1;
              err_q   <= 1'b1;
              state_q <= S_RD_STORE;
            end
          end else if (wr_edge_d) begin
            blk_q <= sd_lba[ADDR_W-10:0];
            ack_q <= 1'b1;
`ifdef SD_IMAGE_WRITE_EN
            if (in_range_d) begin
              baddr_q <= '0;
              state_q <= S_WR_ADDR;
            end else begin
              err_q   <= 1'b1;
              hold_q  <= 1'b1;
              state_q <= S_DONE;
            end
`else
            err_q   <= 1'b1;
            hold_q  <= 1'b1;
            state_q <= S_DONE;
`endif
          end
        end
        S_RD_REQ: begin
          if (mem_ready) begin
            mrd_q   <= 1'b0;
            bdout_q <= mem_dout;
            baddr_q <= idx_q;
            bwr_q   <= 1'b1;
            state_q <= S_RD_STORE;
          end
        end
        S_RD_STORE: begin
          idx_q <= idx_inc_d;
          if (idx_q == 9'd511) begin
            bwr_q   <= 1'b0;
            zfill_q <= 1'b0;
            state_q <= S_DONE;
          end else if (zfill_q) begin
            baddr_q <= idx_inc_d;
          end else begin
            bwr_q   <= 1'b0;
            maddr_q <= byte_addr(blk_q, idx_inc_d);
            mrd_q   <= 1'b1;
            state_q <= S_RD_REQ;
          end
        end
`ifdef SD_IMAGE_WRITE_EN
        // The buffer address is already presented on entry, so the buffer's
        // one-cycle read latency has elapsed by the end of WR_LATCH.
        S_WR_ADDR: begin
          baddr_q <= idx_q;
          state_q <= S_WR_LATCH;
        end
        S_WR_LATCH: begin
          mdin_q  <= sd_buff_din;
          maddr_q <= byte_addr(blk_q, idx_q);
          mwr_q   <= 1'b1;
          state_q <= S_WR_REQ;
        end
        S_WR_REQ: begin
          if (mem_ready) begin
            mwr_q <= 1'b0;
            idx_q <= idx_inc_d;
            if (idx_q == 9'd511) begin
              state_q <= S_DONE;
            end else begin
              baddr_q <= idx_inc_d;
              state_q <= S_WR_ADDR;
            end
          end
        end
`endif
        S_DONE: begin
          if (hold_q) begin
            hold_q <= 1'b0;
          end else begin
            ack_q   <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign sd_ack       = ack_q;
  assign sd_buff_addr = baddr_q;
  assign sd_buff_dout = bdout_q;
  assign sd_buff_wr   = bwr_q;
  assign mem_addr     = maddr_q;
  assign mem_rd       = mrd_q;
  assign mem_wr       = mwr_q;
  assign err          = err_q;

endmodule
`default_nettype wire

// File: tb/tb_sd_image_server.sv
`default_nettype none
// Bench for sd_image_server: table-driven and randomized sector transfers checked against
// a behavioural image memory and sector buffer model.
module tb_sd_image_server;
  localparam int unsigned ADDR_W   = 24;
  localparam int unsigned IMG_BASE = 0;

  logic              CLK = 1'b0;
  logic              RESET_N = 1'b0;
  logic [31:0]       sd_lba = '0;
  logic              sd_rd = 1'b0;
  logic              sd_wr = 1'b0;
  logic              sd_ack;
  logic [8:0]        sd_buff_addr;
  logic [7:0]        sd_buff_dout;
  logic [7:0]        sd_buff_din = '0;
  logic              sd_buff_wr;
  logic [31:0]       img_size = '0;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic              mem_wr;
  logic [7:0]        mem_din;
  logic [7:0]        mem_dout = '0;
  logic              mem_ready;
  logic              err;

  logic model_ready = 1'b0;
  logic man_ready   = 1'b0;
  int   wcnt        = 0;
  int   mem_lat     = 1;
  int   preload_mode = 0;

  int vectors     = 0;
  int miscompares = 0;

  int   err_cnt = 0, rd_cyc = 0, wr_cyc = 0, bwr_cnt = 0, fall_cnt = 0, ack_cyc = 0;
  logic ack_prev = 1'b0;
  logic [ADDR_W-1:0] rd_log[$];
  logic [ADDR_W-1:0] wr_alog[$];
  logic [7:0]        wr_dlog[$];
  logic [7:0]        bufm [512];

  assign mem_ready = model_ready | man_ready;

  sd_image_server #(.ADDR_W(ADDR_W), .IMG_BASE(IMG_BASE)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr),
    .sd_ack(sd_ack), .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
    .sd_buff_din(sd_buff_din), .sd_buff_wr(sd_buff_wr), .img_size(img_size),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_din(mem_din),
    .mem_dout(mem_dout), .mem_ready(mem_ready), .err(err)
  );

  always #5 CLK = ~CLK;

  // Image memory: byte = addr[7:0]^0x5A, completion mem_lat cycles after the request.
  always @(posedge CLK) begin
    model_ready <= 1'b0;
    if ((mem_rd || mem_wr) && !model_ready) begin
      if (wcnt >= mem_lat - 1) begin
        model_ready <= 1'b1;
        mem_dout    <= mem_addr[7:0] ^ 8'h5A;
        wcnt        <= 0;
        if (mem_rd) rd_log.push_back(mem_addr);
        if (mem_wr) begin
          wr_alog.push_back(mem_addr);
          wr_dlog.push_back(mem_din);
        end
      end else begin
        wcnt <= wcnt + 1;
      end
    end else begin
      wcnt <= 0;
    end
  end

  // Sector buffer with one-cycle read latency.
  always @(posedge CLK) begin
    if (preload_mode == 1) begin
      for (int i = 0; i < 512; i++) bufm[i] <= 8'(i);
    end else if (preload_mode == 2) begin
      for (int i = 0; i < 512; i++) bufm[i] <= 8'hEE;
    end else if (sd_buff_wr) begin
      bufm[sd_buff_addr] <= sd_buff_dout;
    end
    sd_buff_din <= bufm[sd_buff_addr];
  end

  always @(posedge CLK) begin
    ack_prev <= sd_ack;
    if (ack_prev && !sd_ack) fall_cnt <= fall_cnt + 1;
    if (sd_ack)     ack_cyc <= ack_cyc + 1;
    if (err)        err_cnt <= err_cnt + 1;
    if (mem_rd)     rd_cyc  <= rd_cyc + 1;
    if (mem_wr)     wr_cyc  <= wr_cyc + 1;
    if (sd_buff_wr) bwr_cnt <= bwr_cnt + 1;
  end

  function automatic bit ref_in_range(input longint unsigned lba, input longint unsigned size);
    longint unsigned max_sectors;
    max_sectors = 64'd1 << (ADDR_W - 9);
    return (size != 0) && (lba < max_sectors) && ((lba + 1) * 512 <= size);
  endfunction

  function automatic logic [ADDR_W-1:0] ref_addr(input logic [31:0] lba, input int i);
    logic [63:0] a;
    a = 64'(IMG_BASE) + 64'(lba) * 64'd512 + 64'(i);
    return a[ADDR_W-1:0];
  endfunction

  task automatic check(input string nm, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic preload(input int mode);
    @(negedge CLK);
    preload_mode = mode;
    @(negedge CLK);
    preload_mode = 0;
  endtask

  task automatic do_xfer(input logic [31:0] lba, input logic [31:0] size,
                         input bit rd, input bit wr, input int repulse_at);
    int n;
    @(negedge CLK);
    sd_lba = lba; img_size = size; sd_rd = rd; sd_wr = wr;
    @(negedge CLK);
    check("ack_rise", sd_ack, 1);
    sd_rd = 1'b0; sd_wr = 1'b0;
    n = 0;
    while (sd_ack && n < 6000) begin
      @(negedge CLK);
      n++;
      if (n == repulse_at)     sd_rd = 1'b1;
      if (n == repulse_at + 3) sd_rd = 1'b0;
    end
    check("ack_done", sd_ack, 0);
    repeat (3) @(negedge CLK);
  endtask

  task automatic run_read(input logic [31:0] lba, input logic [31:0] size, input int lat,
                          input bit ok, input bit both, input int repulse_at);
    int s_err, s_bwr, s_fall, s_wr, s_rd, s_rq, bad_a, bad_d;
    logic [ADDR_W-1:0] ea;
    logic [7:0] ed;
    mem_lat = lat;
    preload(2);
    s_err = err_cnt; s_bwr = bwr_cnt; s_fall = fall_cnt; s_wr = wr_cyc; s_rd = rd_cyc;
    s_rq = rd_log.size();
    do_xfer(lba, size, 1'b1, both, repulse_at);
    check("rd_err", err_cnt - s_err, (ok && !both) ? 0 : 1);
    check("rd_bufwr", bwr_cnt - s_bwr, 512);
    check("rd_ackfall", fall_cnt - s_fall, 1);
    check("rd_memwr", wr_cyc - s_wr, 0);
    bad_a = 0; bad_d = 0;
    for (int i = 0; i < 512; i++) begin
      ea = ref_addr(lba, i);
      ed = ok ? (ea[7:0] ^ 8'h5A) : 8'h00;
      if (bufm[i] != ed) bad_d++;
      if (ok && (s_rq + i >= rd_log.size() || rd_log[s_rq + i] != ea)) bad_a++;
    end
    if (ok) begin
      check("rd_reads", rd_log.size() - s_rq, 512);
      check("rd_addr_order", bad_a, 0);
    end else begin
      check("rd_nomem", rd_cyc - s_rd, 0);
    end
    check("rd_data", bad_d, 0);
  endtask

  task automatic run_wr_reject(input logic [31:0] lba, input logic [31:0] size);
    int s_err, s_ack, s_wr, s_bwr;
    s_err = err_cnt; s_ack = ack_cyc; s_wr = wr_cyc; s_bwr = bwr_cnt;
    do_xfer(lba, size, 1'b0, 1'b1, -1);
    check("wrrej_ack_cycles", ack_cyc - s_ack, 2);
    check("wrrej_err", err_cnt - s_err, 1);
    check("wrrej_memwr", wr_cyc - s_wr, 0);
    check("wrrej_bufwr", bwr_cnt - s_bwr, 0);
  endtask

  typedef struct {
    logic [31:0] lba;
    logic [31:0] size;
    int          lat;
    bit          ok;
  } vec_t;

  vec_t tbl [9];

  initial begin
    int s_bwr, n;
    logic [31:0] rl, rs;

    tbl[0] = '{32'd3,          32'd4096,         3, 1'b1};
    tbl[1] = '{32'd7,          32'd4096,         1, 1'b1};
    tbl[2] = '{32'd8,          32'd4096,         1, 1'b0};
    tbl[3] = '{32'd2,          32'd1024,         1, 1'b0};
    tbl[4] = '{32'd0,          32'd0,            1, 1'b0};
    tbl[5] = '{32'd32767,      32'h0100_0000,    1, 1'b1};
    tbl[6] = '{32'd32768,      32'hFFFF_FFFF,    1, 1'b0};
    tbl[7] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,    1, 1'b0};
    tbl[8] = '{32'd0,          32'd511,          1, 1'b0};

    repeat (3) @(negedge CLK);
    check("rst_ack", sd_ack, 0);
    check("rst_buff_wr", sd_buff_wr, 0);
    check("rst_mem_rd", mem_rd, 0);
    check("rst_mem_wr", mem_wr, 0);
    check("rst_err", err, 0);
    check("rst_buff_addr", sd_buff_addr, 0);
    check("rst_mem_addr", mem_addr, 0);
    RESET_N = 1'b1;
    repeat (2) @(negedge CLK);

    for (int k = 0; k < 9; k++)
      run_read(tbl[k].lba, tbl[k].size, tbl[k].lat, tbl[k].ok, 1'b0, -1);

    for (int k = 0; k < 3; k++) begin
      rl = $urandom_range(0, 15);
      rs = $urandom_range(0, 10) * 512 + ($urandom_range(0, 1) != 0 ? $urandom_range(1, 511) : 0);
      run_read(rl, rs, $urandom_range(1, 2), ref_in_range(rl, rs), 1'b0, -1);
    end

    // Simultaneous edges, then a second sd_rd edge while the transfer is busy.
    run_read(32'd1, 32'd4096, 1, 1'b1, 1'b1, 50);

    run_wr_reject(32'd2, 32'd1024);

`ifdef SD_IMAGE_WRITE_EN
    begin
      int s_wq, s_err, s_bwr2, s_fall, s_rd, bad;
      preload(1);
      mem_lat = 2;
      s_wq = wr_alog.size(); s_err = err_cnt; s_bwr2 = bwr_cnt; s_fall = fall_cnt; s_rd = rd_cyc;
      do_xfer(32'd1, 32'd4096, 1'b0, 1'b1, -1);
      check("wr_count", wr_alog.size() - s_wq, 512);
      bad = 0;
      for (int i = 0; i < 512; i++)
        if (s_wq + i >= wr_alog.size() || wr_alog[s_wq + i] != ref_addr(32'd1, i) ||
            wr_dlog[s_wq + i] != 8'(i)) bad++;
      check("wr_addr_data", bad, 0);
      check("wr_bufwr", bwr_cnt - s_bwr2, 0);
      check("wr_err", err_cnt - s_err, 0);
      check("wr_ackfall", fall_cnt - s_fall, 1);
      check("wr_memrd", rd_cyc - s_rd, 0);
    end
`else
    run_wr_reject(32'd0, 32'd512);
`endif

    // Reset in the middle of a read, while byte 100 is being fetched.
    mem_lat = 3;
    preload(2);
    s_bwr = bwr_cnt;
    @(negedge CLK);
    sd_lba = 32'd3; img_size = 32'd4096; sd_rd = 1'b1;
    @(negedge CLK);
    sd_rd = 1'b0;
    n = 0;
    while (!((bwr_cnt - s_bwr) >= 100 && mem_rd) && n < 2000) begin
      @(negedge CLK);
      n++;
    end
    check("rst_mid_reach", bwr_cnt - s_bwr, 100);
    #1 RESET_N = 1'b0;
    #1;
    check("rst_mid_mem_rd", mem_rd, 0);
    check("rst_mid_ack", sd_ack, 0);
    check("rst_mid_buff_wr", sd_buff_wr, 0);
    repeat (2) @(negedge CLK);
    RESET_N = 1'b1;
    s_bwr = bwr_cnt;
    @(negedge CLK);
    man_ready = 1'b1;
    @(negedge CLK);
    man_ready = 1'b0;
    repeat (3) @(negedge CLK);
    check("late_ready_bufwr", bwr_cnt - s_bwr, 0);
    check("late_ready_ack", sd_ack, 0);
    run_read(32'd2, 32'd4096, 1, 1'b1, 1'b0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
